// File: rtl/text_console_ctrl_if.sv
// text_console_ctrl_if: keyboard handshake, character-memory write port and cursor/scroll status.
interface text_console_ctrl_if;
    logic        in_valid;
    logic [7:0]  in_char;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [4:0]  cur_row;
    logic [6:0]  cur_col;
    logic [4:0]  row_base;
    logic        busy;
    modport master (
        output in_valid, in_char,
        input  in_ready, mem_we, mem_addr, mem_wdata, cur_row, cur_col, row_base, busy
    );
    modport slave (
        input  in_valid, in_char,
        output in_ready, mem_we, mem_addr, mem_wdata, cur_row, cur_col, row_base, busy
    );
endinterface

// File: rtl/text_console_ctrl.sv
// text_console_ctrl: cursor and write sequencer for the VGA text-mode character buffer.
// Define CONSOLE_SCROLL_EN for hardware scrolling via row_base; otherwise the cursor wraps to the top.
module text_console_ctrl #(
    parameter int         COLS       = 70,
    parameter int         ROWS       = 30,
    parameter logic [7:0] CLEAR_CHAR = 8'h00
) (
    input logic                clk,
    input logic                reset,
    text_console_ctrl_if.slave bus
);
    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
    typedef enum logic [1:0] {INIT_CLR, IDLE, WR, SCROLL_CLR} state_t;
    state_t      state_q, state_d;
    logic [4:0]  log_row_q, log_row_d;
    logic [6:0]  col_q, col_d;
    logic [5:0]  clr_row_q, clr_row_d;
    logic [7:0]  clr_col_q, clr_col_d;
    logic [7:0]  char_q, char_d;
    logic        mem_we_q, mem_we_d;
    logic [11:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [4:0]  base;
    logic [7:0]  ch;
    logic        is_print, is_bs, is_nl, last_row, do_wr;
    logic [4:0]  bs_row, nl_row, new_row, wr_row;
    logic [6:0]  bs_col, new_col, wr_col;

    function automatic logic [4:0] phys(input logic [4:0] r, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, r} + {1'b0, b};
        return (s >= 6'(ROWS)) ? 5'(s - 6'(ROWS)) : s[4:0];
    endfunction

`ifdef CONSOLE_SCROLL_EN
    logic [4:0] row_base_q, row_base_d;
    assign base   = row_base_q;
    assign nl_row = last_row ? log_row_q : log_row_q + 5'd1;
`else
    assign base   = 5'd0;
    assign nl_row = last_row ? 5'd0 : log_row_q + 5'd1;
`endif

    // The same decode serves the accept cycle (live in_char) and WR (latched char, unchanged cursor).
    assign ch       = (state_q == IDLE) ? bus.in_char : char_q;
    assign is_print = (ch >= 8'h20) && (ch <= 8'h7e);
    assign is_bs    = (ch == 8'h08) && (col_q != 7'd0 || log_row_q != 5'd0);
    assign is_nl    = (ch == 8'h0a) || (is_print && col_q == COL_LAST);
    assign last_row = log_row_q == ROW_LAST;
    assign bs_row   = (col_q != 7'd0) ? log_row_q : log_row_q - 5'd1;
    assign bs_col   = (col_q != 7'd0) ? col_q - 7'd1 : COL_LAST;
    assign new_row  = is_nl ? nl_row : is_bs ? bs_row : log_row_q;
    assign new_col  = is_nl ? 7'd0 : is_print ? col_q + 7'd1 : is_bs ? bs_col : col_q;
    assign do_wr    = is_print || is_bs;
    assign wr_row   = is_bs ? bs_row : log_row_q;
    assign wr_col   = is_bs ? bs_col : col_q;

    always_comb begin
        state_d     = state_q;
        log_row_d   = log_row_q;
        col_d       = col_q;
        clr_row_d   = clr_row_q;
        clr_col_d   = clr_col_q;
        char_d      = char_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef CONSOLE_SCROLL_EN
        row_base_d  = row_base_q;
`endif
        case (state_q)
            INIT_CLR: begin
                if (clr_row_q == 6'(ROWS)) begin
                    state_d = IDLE;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {clr_row_q[4:0], clr_col_q[6:0]};
                    mem_wdata_d = CLEAR_CHAR;
                    clr_col_d   = (clr_col_q == 8'(COLS - 1)) ? 8'd0 : clr_col_q + 8'd1;
                    clr_row_d   = (clr_col_q == 8'(COLS - 1)) ? clr_row_q + 6'd1 : clr_row_q;
                end
            end
            IDLE: begin
                if (bus.in_valid) begin
                    state_d     = WR;
                    char_d      = bus.in_char;
                    mem_we_d    = do_wr;
                    mem_addr_d  = {phys(wr_row, base), wr_col};
                    mem_wdata_d = is_bs ? 8'h20 : ch;
                end
            end
            WR: begin
                state_d   = IDLE;
                log_row_d = new_row;
                col_d     = new_col;
`ifdef CONSOLE_SCROLL_EN
                // Launch clear write 0 here so the scroll writes follow WR back to back.
                if (is_nl && last_row) begin
                    state_d     = SCROLL_CLR;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {base, 7'd0};
                    mem_wdata_d = CLEAR_CHAR;
                    clr_col_d   = 8'd1;
                end
`endif
            end
`ifdef CONSOLE_SCROLL_EN
            SCROLL_CLR: begin
                if (clr_col_q == 8'(COLS)) begin
                    state_d    = IDLE;
                    clr_col_d  = 8'd0;
                    row_base_d = (row_base_q == ROW_LAST) ? 5'd0 : row_base_q + 5'd1;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {row_base_q, clr_col_q[6:0]};
                    mem_wdata_d = CLEAR_CHAR;
                    clr_col_d   = clr_col_q + 8'd1;
                end
            end
`endif
            default: state_d = INIT_CLR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT_CLR;
            log_row_q   <= '0;
            col_q       <= '0;
            clr_row_q   <= '0;
            clr_col_q   <= '0;
            char_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef CONSOLE_SCROLL_EN
            row_base_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            log_row_q   <= log_row_d;
            col_q       <= col_d;
            clr_row_q   <= clr_row_d;
            clr_col_q   <= clr_col_d;
            char_q      <= char_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef CONSOLE_SCROLL_EN
            row_base_q  <= row_base_d;
`endif
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.busy      = (state_q == INIT_CLR) || (state_q == SCROLL_CLR);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cur_row   = phys(log_row_q, base);
    assign bus.cur_col   = col_q;
    assign bus.row_base  = base;
endmodule

// File: tb/tb_text_console_ctrl.sv
// tb_text_console_ctrl: randomized check of text_console_ctrl against a logical-screen model.
// Works with or without CONSOLE_SCROLL_EN; the model follows the same macro.
module tb_text_console_ctrl;
    localparam int         COLS = 70;
    localparam int         ROWS = 30;
    localparam logic [7:0] CLR  = 8'h00;

    logic clk = 1'b0;
    logic reset = 1'b1;
    text_console_ctrl_if bus();
    text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .CLEAR_CHAR(CLR)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          idle_we = 0;
    logic [19:0] wq[$];
    logic [19:0] expq[$];
    int          wcyc[$];
    logic [7:0]  shadow [4096];
    logic [7:0]  scr [ROWS][COLS];
    int          lr, lc, base;

    // Write monitor: records every memory write and mirrors it into a shadow memory.
    always @(negedge clk) begin
        cyc++;
        if (bus.mem_we === 1'b1) begin
            wq.push_back({bus.mem_addr, bus.mem_wdata});
            wcyc.push_back(cyc);
            shadow[bus.mem_addr] = bus.mem_wdata;
            if (bus.in_ready === 1'b1) idle_we++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [11:0] addr(input int r, input int c);
        int p;
        p = (r + base) % ROWS;
        return {p[4:0], c[6:0]};
    endfunction

    function automatic logic [39:0] outs();
        return {bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                bus.cur_row, bus.cur_col, bus.row_base, bus.busy};
    endfunction

    function automatic void newline();
        lc = 0;
        if (lr < ROWS - 1) begin
            lr++;
        end else begin
`ifdef CONSOLE_SCROLL_EN
            for (int k = 0; k < COLS; k++) expq.push_back({addr(0, k), CLR});
            for (int r = 0; r < ROWS - 1; r++)
                for (int k = 0; k < COLS; k++) scr[r][k] = scr[r + 1][k];
            for (int k = 0; k < COLS; k++) scr[ROWS - 1][k] = CLR;
            base = (base + 1) % ROWS;
`else
            lr = 0;
`endif
        end
    endfunction

    function automatic void model(input logic [7:0] ch, output logic wr, output logic [19:0] w);
        wr = 1'b0;
        w = '0;
        expq.delete();
        if (ch >= 8'h20 && ch <= 8'h7e) begin
            wr = 1'b1;
            w = {addr(lr, lc), ch};
            expq.push_back(w);
            scr[lr][lc] = ch;
            if (lc < COLS - 1) lc++;
            else newline();
        end else if (ch == 8'h0a) begin
            newline();
        end else if (ch == 8'h08 && (lc > 0 || lr > 0)) begin
            if (lc > 0) begin
                lc--;
            end else begin
                lr--;
                lc = COLS - 1;
            end
            wr = 1'b1;
            w = {addr(lr, lc), 8'h20};
            expq.push_back(w);
            scr[lr][lc] = 8'h20;
        end
    endfunction

    function automatic logic [7:0] rand_char();
        int p;
        p = $urandom_range(99);
        if (p < 55) return 8'($urandom_range(126, 32));
        if (p < 70) return 8'h0a;
        if (p < 86) return 8'h08;
        if (p < 92) return 8'h0d;
        if (p < 96) return 8'($urandom_range(31, 0));
        return 8'($urandom_range(255, 127));
    endfunction

    task automatic check_screen(input string tag);
        int bad = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (shadow[addr(r, c)] !== scr[r][c]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic accept(input logic [7:0] ch, output logic wr, output logic [19:0] w);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("accept_ready", bus.in_ready, 1'b1);
        wq.delete();
        bus.in_valid = 1'b1;
        bus.in_char = ch;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_char = 8'($urandom);
        model(ch, wr, w);
    endtask

    task automatic send(input logic [7:0] ch);
        logic        wr;
        logic [19:0] w;
        int          n = 0;
        int          bad = 0;
        accept(ch, wr, w);
        tick();
        chk("wr_ready", bus.in_ready, 1'b0);
        chk("wr_we", bus.mem_we, wr);
        if (wr) chk("wr_word", {bus.mem_addr, bus.mem_wdata}, w);
        while (bus.in_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("done_ready", bus.in_ready, 1'b1);
        chk("write_count", wq.size(), expq.size());
        for (int i = 0; i < wq.size() && i < expq.size(); i++)
            if (wq[i] !== expq[i]) bad++;
        chk("write_seq", bad, 0);
        chk("cursor", {bus.cur_row, bus.cur_col, bus.row_base, bus.busy}, {addr(lr, lc), 5'(base), 1'b0});
    endtask

    task automatic do_reset();
        int n = 0;
        int bad = 0;
        int c0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4096; i++) shadow[i] = 8'hee;
        repeat (3) @(posedge clk);
        tick();
        chk("reset_hold", outs(), 40'h1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("reset_after", outs(), 40'h1);
        c0 = cyc;
        wq.delete();
        wcyc.delete();
        while (bus.in_ready !== 1'b1 && n < 2300) begin
            tick();
            n++;
        end
        chk("init_ready_cycle", n, ROWS * COLS + 1);
        chk("init_count", wq.size(), ROWS * COLS);
        chk("init_first", (wcyc.size() > 0) ? wcyc[0] - c0 : 0, 1);
        chk("init_span", (wcyc.size() > 0) ? wcyc[wcyc.size() - 1] - wcyc[0] : 0, ROWS * COLS - 1);
        for (int i = 0; i < wq.size(); i++) begin
            int r = i / COLS;
            int c = i % COLS;
            if (wq[i] !== {r[4:0], c[6:0], CLR}) bad++;
        end
        chk("init_seq", bad, 0);
        lr = 0;
        lc = 0;
        base = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = CLR;
        chk("init_status", {bus.cur_row, bus.cur_col, bus.row_base, bus.busy}, 18'h0);
        check_screen("init_screen");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        wr;
        logic [19:0] w;
        int          pb;
        bus.in_valid = 1'b0;
        bus.in_char = 8'h00;
        do_reset();
        send(8'h08);
        chk("bs_origin", {bus.cur_row, bus.cur_col}, 12'h0);
        send("A");
        send("B");
        chk("ab_col", bus.cur_col, 7'd2);
        chk("ab_cells", {shadow[12'h000], shadow[12'h001]}, 16'h4142);
        send(8'h0a);
        repeat (COLS) send("x");
        chk("line_wrap", {bus.cur_row, bus.cur_col}, {5'd2, 7'd0});
        send(8'h08);
        chk("bs_wrap", {bus.cur_row, bus.cur_col}, {5'd1, 7'd69});
        chk("bs_cell", shadow[{5'd1, 7'd69}], 8'h20);
        while (lr < ROWS - 1) send(8'h0a);
        send(8'h0a);
        chk("bottom_pos", {bus.cur_row, bus.cur_col}, 12'h0);
        chk("bottom_base", bus.row_base, 5'(base));
        check_screen("screen_dir");
        for (int i = 0; i < 400; i++) begin
            send(rand_char());
            if (i % 25 == 24) check_screen("screen_rand");
        end
`ifdef CONSOLE_SCROLL_EN
        while (lr < ROWS - 1) send(8'h0a);
        pb = base;
        accept(8'h0a, wr, w);
        repeat (36) tick();
        chk("abort_pre", {bus.mem_we, bus.mem_addr}, {1'b1, 5'(pb), 7'd34});
`else
        pb = 0;
        accept("Q", wr, w);
        tick();
        chk("abort_pre", {bus.mem_we, bus.mem_addr}, {1'b1, w[19:8]});
`endif
        reset = 1'b1;
        @(posedge clk);
        tick();
        chk("abort_we", bus.mem_we, 1'b0);
        chk("abort_base", bus.row_base, 5'd0);
        do_reset();
        for (int i = 0; i < 60; i++) send(rand_char());
        check_screen("screen_end");
        chk("idle_we", idle_we, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
